// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared definitions for the MEM/WB skid stage: writeback select codes and buffer states.
// No logic; latency and backpressure are properties of mem_wb_skid_stage.
// Imported by the stage, its beat register and the bench.
package mem_wb_skid_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_FPU = 2'd3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_beat_reg.sv
// Enable-loaded register holding one packed writeback beat.
// Latency: one edge from en to q; async active-high reset clears to zero.
// No handshake of its own; the parent decides when to load.
module wb_beat_reg
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register as a two-entry skid buffer feeding the writeback mux.
// Latency: one cycle from accept into an empty stage to VALID_OUT; full throughput.
// READY_OUT is registered (low only when both entries hold beats); optional STALL_CNT under MEM_WB_STALL_CNT_EN.
module mem_wb_skid_stage
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] ALU_IN,
    input  logic [DATA_W-1:0] MEM_IN,
    input  logic [DATA_W-1:0] PC4_IN,
    input  logic [DATA_W-1:0] FPU_IN,
    input  logic [1:0]        SEL_IN,
    input  logic [RD_W-1:0]   RD_IN,
    input  logic              REGWR_IN,
    input  logic              VALID_IN,
    output logic              READY_OUT,
    output logic [DATA_W-1:0] WB_INPUT1,
    output logic [DATA_W-1:0] WB_INPUT2,
    output logic [DATA_W-1:0] WB_INPUT3,
    output logic [DATA_W-1:0] WB_INPUT4,
    output logic [1:0]        WB_SELECT,
    output logic [RD_W-1:0]   WB_RD,
    output logic              WB_REGWR,
    output logic              VALID_OUT,
    input  logic              READY_IN
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [15:0]       STALL_CNT
`endif
);

    localparam int BEAT_W = 4 * DATA_W + 2 + RD_W + 1;

    wb_state_t         state_q, state_d;
    logic              ready_q;
    logic              accept, deliver;
    logic              main_en, skid_en, main_from_skid;
    logic [BEAT_W-1:0] in_beat, main_d, main_q, skid_q;
    logic              main_regwr;

    assign in_beat = {ALU_IN, MEM_IN, PC4_IN, FPU_IN, SEL_IN, RD_IN, REGWR_IN};
    assign main_d  = main_from_skid ? skid_q : in_beat;

    assign READY_OUT = ready_q;
    assign VALID_OUT = (state_q != EMPTY);
    assign accept    = VALID_IN && ready_q;
    assign deliver   = VALID_OUT && READY_IN;

    assign {WB_INPUT1, WB_INPUT2, WB_INPUT3, WB_INPUT4, WB_SELECT, WB_RD, main_regwr} = main_q;
    assign WB_REGWR = main_regwr && VALID_OUT;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // READY_OUT is low here, so only a delivery can move us.
                if (deliver) begin
                    state_d        = ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (FLUSH) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
        end
    end

    wb_beat_reg #(.W(BEAT_W)) u_main (
        .clk (CLK),
        .rst (RESET),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    wb_beat_reg #(.W(BEAT_W)) u_skid (
        .clk (CLK),
        .rst (RESET),
        .en  (skid_en),
        .d   (in_beat),
        .q   (skid_q)
    );

`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q <= '0;
        end else if (FLUSH) begin
            stall_q <= '0;
        end else if (VALID_OUT && !READY_IN && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed beats, scoreboard queue checked by a negedge monitor.
module tb_mem_wb_skid_stage;
    import mem_wb_skid_stage_pkg::*;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [31:0] fpu;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        regwr;
    } beat_t;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              FLUSH = 1'b0;
    logic [DATA_W-1:0] ALU_IN = '0, MEM_IN = '0, PC4_IN = '0, FPU_IN = '0;
    logic [1:0]        SEL_IN = '0;
    logic [RD_W-1:0]   RD_IN = '0;
    logic              REGWR_IN = 1'b0;
    logic              VALID_IN = 1'b0;
    logic              READY_OUT;
    logic [DATA_W-1:0] WB_INPUT1, WB_INPUT2, WB_INPUT3, WB_INPUT4;
    logic [1:0]        WB_SELECT;
    logic [RD_W-1:0]   WB_RD;
    logic              WB_REGWR;
    logic              VALID_OUT;
    logic              READY_IN = 1'b0;
`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0]       STALL_CNT;
`endif

    mem_wb_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .ALU_IN    (ALU_IN),
        .MEM_IN    (MEM_IN),
        .PC4_IN    (PC4_IN),
        .FPU_IN    (FPU_IN),
        .SEL_IN    (SEL_IN),
        .RD_IN     (RD_IN),
        .REGWR_IN  (REGWR_IN),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .WB_INPUT1 (WB_INPUT1),
        .WB_INPUT2 (WB_INPUT2),
        .WB_INPUT3 (WB_INPUT3),
        .WB_INPUT4 (WB_INPUT4),
        .WB_SELECT (WB_SELECT),
        .WB_RD     (WB_RD),
        .WB_REGWR  (WB_REGWR),
        .VALID_OUT (VALID_OUT),
        .READY_IN  (READY_IN)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .STALL_CNT (STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every delivery must match the oldest accepted beat.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (VALID_OUT && READY_IN) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(VALID_OUT), 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("wb_input1", 64'(WB_INPUT1), 64'(e.alu));
                    check("wb_input2", 64'(WB_INPUT2), 64'(e.mem));
                    check("wb_input3", 64'(WB_INPUT3), 64'(e.pc4));
                    check("wb_input4", 64'(WB_INPUT4), 64'(e.fpu));
                    check("wb_select", 64'(WB_SELECT), 64'(e.sel));
                    check("wb_rd",     64'(WB_RD),     64'(e.rd));
                    check("wb_regwr",  64'(WB_REGWR),  64'(e.regwr));
                end
            end else if (!VALID_OUT) begin
                check("regwr_idle", 64'(WB_REGWR), 64'd0);
            end
        end
    end

    task automatic drive(input beat_t b);
        ALU_IN   = b.alu;
        MEM_IN   = b.mem;
        PC4_IN   = b.pc4;
        FPU_IN   = b.fpu;
        SEL_IN   = b.sel;
        RD_IN    = b.rd;
        REGWR_IN = b.regwr;
    endtask

    // Offer a beat until the stage takes it; called just after a rising edge.
    task automatic send(input beat_t b);
        int w;
        drive(b);
        VALID_IN = 1'b1;
        w = 0;
        @(negedge CLK);
        while (!READY_OUT && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (!READY_OUT) begin
            check("send_timeout", 64'(READY_OUT), 64'd1);
            VALID_IN = 1'b0;
            return;
        end
        exp_q.push_back(b);
        @(posedge CLK);
        #1;
        VALID_IN = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge CLK);
            w++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_valid_out"}, 64'(VALID_OUT), 64'd0);
        check({tag, "_ready_out"}, 64'(READY_OUT), 64'd1);
        check({tag, "_wb_regwr"},  64'(WB_REGWR),  64'd0);
        check({tag, "_wb_input1"}, 64'(WB_INPUT1), 64'd0);
        check({tag, "_wb_input2"}, 64'(WB_INPUT2), 64'd0);
        check({tag, "_wb_input3"}, 64'(WB_INPUT3), 64'd0);
        check({tag, "_wb_input4"}, 64'(WB_INPUT4), 64'd0);
        check({tag, "_wb_select"}, 64'(WB_SELECT), 64'd0);
        check({tag, "_wb_rd"},     64'(WB_RD),     64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t b0, ba, bb, bc, bd, be, bf, bg, bh, bz, bs;
        int    c0;

        b0 = '{alu: 32'h0000_0011, mem: 32'hAAAA_0001, pc4: 32'h0000_1004, fpu: 32'h3F80_0000,
               sel: WB_SEL_ALU, rd: 5'd5, regwr: 1'b1};
        ba = '{alu: 32'hA000_00A1, mem: 32'hA000_00A2, pc4: 32'hA000_00A3, fpu: 32'hA000_00A4,
               sel: WB_SEL_MEM, rd: 5'd1, regwr: 1'b1};
        bb = '{alu: 32'hB000_00B1, mem: 32'hB000_00B2, pc4: 32'hB000_00B3, fpu: 32'hB000_00B4,
               sel: WB_SEL_PC4, rd: 5'd2, regwr: 1'b0};
        bc = '{alu: 32'hC000_00C1, mem: 32'hC000_00C2, pc4: 32'hC000_00C3, fpu: 32'hC000_00C4,
               sel: WB_SEL_FPU, rd: 5'd3, regwr: 1'b1};
        bd = '{alu: 32'hD1, mem: 32'hD2, pc4: 32'hD3, fpu: 32'hD4, sel: 2'd1, rd: 5'd20, regwr: 1'b1};
        be = '{alu: 32'hE1, mem: 32'hE2, pc4: 32'hE3, fpu: 32'hE4, sel: 2'd2, rd: 5'd21, regwr: 1'b1};
        bf = '{alu: 32'hF1, mem: 32'hF2, pc4: 32'hF3, fpu: 32'hF4, sel: 2'd3, rd: 5'd22, regwr: 1'b1};
        bg = '{alu: 32'h61, mem: 32'h62, pc4: 32'h63, fpu: 32'h64, sel: 2'd0, rd: 5'd23, regwr: 1'b1};
        bh = '{alu: 32'h71, mem: 32'h72, pc4: 32'h73, fpu: 32'h74, sel: 2'd1, rd: 5'd24, regwr: 1'b0};
        bz = '{alu: 32'h5A5A_0001, mem: 32'h5A5A_0002, pc4: 32'h5A5A_0003, fpu: 32'h5A5A_0004,
               sel: WB_SEL_FPU, rd: 5'd31, regwr: 1'b1};

        // Reset values
        #2 RESET = 1'b1;
        #1 check_reset_outs("reset");
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        check_reset_outs("post_reset");

        // Single beat, one-cycle latency, then back to empty
        READY_IN = 1'b1;
        send(b0);
        check("lat_valid_out", 64'(VALID_OUT), 64'd1);
        check("lat_wb_input1", 64'(WB_INPUT1), 64'h11);
        check("lat_wb_rd",     64'(WB_RD),     64'd5);
        check("lat_wb_regwr",  64'(WB_REGWR),  64'd1);
        @(posedge CLK);
        #1;
        check("single_empty_valid", 64'(VALID_OUT), 64'd0);
        check("single_empty_ready", 64'(READY_OUT), 64'd1);
        drain();

        // Back-pressure: A and B fill the stage, C waits upstream
        READY_IN = 1'b0;
        send(ba);
        send(bb);
        fork
            begin
                repeat (3) begin
                    @(negedge CLK);
                    check("full_ready_out", 64'(READY_OUT), 64'd0);
                    check("full_valid_out", 64'(VALID_OUT), 64'd1);
                    check("full_head_alu",  64'(WB_INPUT1), 64'(ba.alu));
                end
                @(posedge CLK);
                #1 READY_IN = 1'b1;
            end
            send(bc);
        join
        drain();

        // Streaming: one beat per cycle, select cycling through all codes
        READY_IN = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            bs = '{alu: 32'h100 + i, mem: 32'h200 + i, pc4: 32'h300 + i, fpu: 32'h400 + i,
                   sel: 2'(i), rd: 5'(i + 8), regwr: 1'(i)};
            send(bs);
        end
        check("stream_cycles", 64'(cyc - c0), 64'd8);
        drain();

        // Flush while full, with a beat offered on the same edge
        READY_IN = 1'b0;
        send(bd);
        send(be);
        drive(bf);
        VALID_IN = 1'b1;
        FLUSH    = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH    = 1'b0;
        VALID_IN = 1'b0;
        exp_q.delete();
        check("flush_valid_out", 64'(VALID_OUT), 64'd0);
        check("flush_wb_regwr",  64'(WB_REGWR),  64'd0);
        check("flush_ready_out", 64'(READY_OUT), 64'd1);
`ifdef MEM_WB_STALL_CNT_EN
        check("flush_stall_cnt", 64'(STALL_CNT), 64'd0);
`endif
        READY_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("flush_no_beat", 64'(VALID_OUT), 64'd0);

        // Stall counting, then asynchronous reset mid-cycle while full
        READY_IN = 1'b0;
        send(bg);
        send(bh);
        repeat (4) @(posedge CLK);
        #1;
`ifdef MEM_WB_STALL_CNT_EN
        check("stall_cnt_5", 64'(STALL_CNT), 64'd5);
`endif
        check("pre_reset_valid", 64'(VALID_OUT), 64'd1);
        #2 RESET = 1'b1;
        #1;
        check_reset_outs("async_reset");
`ifdef MEM_WB_STALL_CNT_EN
        check("reset_stall_cnt", 64'(STALL_CNT), 64'd0);
`endif
        exp_q.delete();
        @(posedge CLK);
        #1 RESET = 1'b0;

        // Stage still works after reset
        READY_IN = 1'b1;
        send(bz);
        drain();
        repeat (2) @(posedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
